keypad_emulator: RTL and testbench

//  Behavioural-synthesizable model of a 4x4 matrix keypad: the responder end of the col-scan/row-sense

---
 rtl/keypad_emulator.sv | 189 ++++++++++++++++++
 tb/tb_keypad_emulator.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/keypad_emulator.sv
// 4x4 matrix keypad responder: plays each accepted key press as bounce/hold/bounce/gap phases
// and pulls the key's row low while its column is driven low and the contact is closed.
module keypad_emulator #(
  parameter int HOLD_CYCLES   = 64,
  parameter int BOUNCE_CYCLES = 8,
  parameter int BOUNCE_PERIOD = 2,
  parameter int GAP_CYCLES    = 16,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col,
  output logic [3:0] row,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic       key_abort,
  output logic       busy,
  output logic       contact,
  output logic       key_done
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_BOUNCE_IN  = 3'd1,
    ST_HOLD       = 3'd2,
    ST_BOUNCE_OUT = 3'd3,
    ST_GAP        = 3'd4
  } state_t;

  localparam bit              HAS_BOUNCE  = (BOUNCE_CYCLES > 0);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] BOUNCE_LAST = CNT_W'((BOUNCE_CYCLES > 0) ? (BOUNCE_CYCLES - 1) : 0);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(BOUNCE_PERIOD - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);

  // Returns {column index, row index} of a hex key on the matrix.
  function automatic logic [3:0] key_pos(input logic [3:0] code);
    case (code)
      4'hd: key_pos = 4'b00_00;
      4'hc: key_pos = 4'b00_01;
      4'hb: key_pos = 4'b00_10;
      4'ha: key_pos = 4'b00_11;
      4'hf: key_pos = 4'b01_00;
      4'h9: key_pos = 4'b01_01;
      4'h6: key_pos = 4'b01_10;
      4'h3: key_pos = 4'b01_11;
      4'h0: key_pos = 4'b10_00;
      4'h8: key_pos = 4'b10_01;
      4'h5: key_pos = 4'b10_10;
      4'h2: key_pos = 4'b10_11;
      4'he: key_pos = 4'b11_00;
      4'h7: key_pos = 4'b11_01;
      4'h4: key_pos = 4'b11_10;
      4'h1: key_pos = 4'b11_11;
      default: key_pos = 4'b00_00;
    endcase
  endfunction

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [CNT_W-1:0] tog_r, tog_s;
  logic             contact_r, contact_s;
  logic             key_done_r, key_done_s;
  logic             key_ready_r, busy_r;
  logic [1:0]       key_col_r, key_row_r;
  logic             load_key_s;
  logic [3:0]       pos_s;
  logic [3:0]       row_s;

  assign pos_s = key_pos(key_code);

  // Next-state, phase counter and contact waveform; abort jumps any active phase to GAP.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r + CNT_W'(1);
    tog_s      = tog_r;
    contact_s  = contact_r;
    key_done_s = 1'b0;
    load_key_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_s = '0;
        if (key_valid) begin
          load_key_s = 1'b1;
          contact_s  = 1'b1;
          tog_s      = '0;
          state_s    = HAS_BOUNCE ? ST_BOUNCE_IN : ST_HOLD;
        end else begin
          contact_s = 1'b0;
        end
      end
      ST_BOUNCE_IN, ST_BOUNCE_OUT: begin
        if (key_abort) begin
          state_s   = ST_GAP;
          cnt_s     = '0;
          contact_s = 1'b0;
        end else if (cnt_r == BOUNCE_LAST) begin
          state_s   = (state_r == ST_BOUNCE_IN) ? ST_HOLD : ST_GAP;
          cnt_s     = '0;
          contact_s = (state_r == ST_BOUNCE_IN);
        end else if (tog_r == PERIOD_LAST) begin
          tog_s     = '0;
          contact_s = ~contact_r;
        end else begin
          tog_s = tog_r + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (key_abort) begin
          state_s   = ST_GAP;
          cnt_s     = '0;
          contact_s = 1'b0;
        end else if (cnt_r == HOLD_LAST) begin
          state_s   = HAS_BOUNCE ? ST_BOUNCE_OUT : ST_GAP;
          cnt_s     = '0;
          tog_s     = '0;
          contact_s = 1'b0;
        end else begin
          contact_s = 1'b1;
        end
      end
      ST_GAP: begin
        contact_s = 1'b0;
        if (cnt_r == GAP_LAST) begin
          state_s    = ST_IDLE;
          cnt_s      = '0;
          key_done_s = 1'b1;
        end else begin
          key_done_s = 1'b0;
        end
      end
      default: begin
        state_s   = ST_IDLE;
        cnt_s     = '0;
        contact_s = 1'b0;
      end
    endcase
  end

  // State, counters and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      tog_r       <= '0;
      contact_r   <= 1'b0;
      key_done_r  <= 1'b0;
      key_ready_r <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      tog_r       <= tog_s;
      contact_r   <= contact_s;
      key_done_r  <= key_done_s;
      key_ready_r <= (state_s == ST_IDLE);
      busy_r      <= (state_s != ST_IDLE);
    end
  end

  // Latched key position, captured on acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_col_r <= 2'd0;
      key_row_r <= 2'd0;
    end else if (load_key_s) begin
      key_col_r <= pos_s[3:2];
      key_row_r <= pos_s[1:0];
    end
  end

  // Same-cycle column-to-row path: the scanner sees the closure without a register in between.
  always_comb begin
    row_s = 4'b1111;
    if (contact_r && (col[key_col_r] == 1'b0)) begin
      row_s[key_row_r] = 1'b0;
    end else begin
      row_s = 4'b1111;
    end
  end

  assign row       = row_s;
  assign contact   = contact_r;
  assign key_done  = key_done_r;
  assign key_ready = key_ready_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: randomized presses/aborts against a phase-list reference model,
// plus a no-bounce instance and async reset checks.
module tb_keypad_emulator;

  logic       clk;
  logic       reset;
  logic [3:0] col, key_code, row;
  logic       key_valid, key_abort, key_ready, busy, contact, key_done;
  logic [3:0] col_b, key_code_b, row_b;
  logic       key_valid_b, key_abort_b, key_ready_b, busy_b, contact_b, key_done_b;

  int n_tests;
  int n_fail;
  bit exp_q[$];

  localparam logic [3:0] KEYMAP [4][4] = '{
    '{4'hd, 4'hc, 4'hb, 4'ha},
    '{4'hf, 4'h9, 4'h6, 4'h3},
    '{4'h0, 4'h8, 4'h5, 4'h2},
    '{4'he, 4'h7, 4'h4, 4'h1}
  };

  keypad_emulator u_dut (
    .clk(clk), .reset(reset), .col(col), .row(row), .key_code(key_code),
    .key_valid(key_valid), .key_ready(key_ready), .key_abort(key_abort),
    .busy(busy), .contact(contact), .key_done(key_done)
  );

  keypad_emulator #(.HOLD_CYCLES(20), .BOUNCE_CYCLES(0)) u_b0 (
    .clk(clk), .reset(reset), .col(col_b), .row(row_b), .key_code(key_code_b),
    .key_valid(key_valid_b), .key_ready(key_ready_b), .key_abort(key_abort_b),
    .busy(busy_b), .contact(contact_b), .key_done(key_done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Expected contact value for every cycle after acceptance, until the done cycle.
  function automatic void build_wave(input int b, input int p, input int h, input int g);
    exp_q.delete();
    for (int i = 0; i < b; i++) exp_q.push_back(((i / p) % 2) == 0);
    for (int i = 0; i < h; i++) exp_q.push_back(1'b1);
    for (int i = 0; i < b; i++) exp_q.push_back(((i / p) % 2) == 1);
    for (int i = 0; i < g; i++) exp_q.push_back(1'b0);
  endfunction

  function automatic logic [3:0] model_row(input logic [3:0] code, input logic [3:0] c, input bit con);
    model_row = 4'b1111;
    for (int ci = 0; ci < 4; ci++)
      for (int ri = 0; ri < 4; ri++)
        if (con && KEYMAP[ci][ri] == code && c[ci] == 1'b0) model_row[ri] = 1'b0;
  endfunction

  // One press on the default instance; abort_at >= 0 raises abort after that many cycles.
  task automatic press(input logic [3:0] code, input int abort_at, input bit follow,
                       input logic [3:0] next_code);
    build_wave(8, 2, 64, 16);
    if (abort_at >= 0) begin
      while (exp_q.size() > abort_at + 1) void'(exp_q.pop_back());
      for (int i = 0; i < 16; i++) exp_q.push_back(1'b0);
    end
    key_code  = code;
    key_valid = 1'b1;
    key_abort = (abort_at >= 0);
    check("ready_idle", 32'(key_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    key_valid = follow;
    key_code  = follow ? next_code : 4'($urandom_range(0, 15));
    key_abort = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      col = 4'($urandom_range(0, 15));
      #1;
      check("contact", 32'(contact), 32'(exp_q[i]));
      check("row", 32'(row), 32'(model_row(code, col, exp_q[i])));
      check("ready_busy", 32'({key_ready, busy, key_done}), 32'b010);
      if (abort_at >= 0 && i >= abort_at) key_abort = 1'b1;
      @(negedge clk);
    end
    col = 4'($urandom_range(0, 15));
    #1;
    check("done_cycle", 32'({key_done, key_ready, busy, contact}), 32'b1100);
    check("row_done", 32'(row), 32'hf);
    key_abort = 1'b0;
    if (!follow) begin
      @(negedge clk);
      check("done_pulse_end", 32'(key_done), 32'd0);
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    reset = 1'b1; col = 4'b1111; key_code = 4'h0; key_valid = 1'b0; key_abort = 1'b0;
    col_b = 4'b1111; key_code_b = 4'h0; key_valid_b = 1'b0; key_abort_b = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_state", 32'({row, key_ready, busy, contact, key_done}), 32'b1111_1000);
    reset = 1'b0;

    // Idle scan: no key, rows stay released
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      col = ~(4'b0001 << c);
      #1;
      check("idle_row", 32'(row), 32'hf);
      check("idle_status", 32'({key_ready, busy}), 32'b10);
    end

    @(negedge clk);
    press(4'ha, -1, 1'b0, 4'h0);
    press(4'h1, -1, 1'b1, 4'h2);
    press(4'h2, -1, 1'b0, 4'h0);
    for (int k = 0; k < 3; k++) press(4'($urandom_range(0, 15)), -1, 1'b0, 4'h0);
    press(4'h5, 40, 1'b0, 4'h0);
    for (int k = 0; k < 2; k++)
      press(4'($urandom_range(0, 15)), int'($urandom_range(0, 79)), 1'b0, 4'h0);

    // Reset in the middle of HOLD releases the row immediately
    key_code = 4'h1; key_valid = 1'b1; col = 4'b0111;
    @(posedge clk);
    @(negedge clk);
    key_valid = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    check("hold_row", 32'(row), 32'h7);
    reset = 1'b1;
    #1;
    check("async_rst", 32'({row, contact, key_ready, busy}), 32'b1111_010);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("post_rst", 32'({row, contact, key_ready}), 32'b1111_01);

    // No-bounce instance: key 9, hold 20, gap 16
    key_code_b = 4'h9; key_valid_b = 1'b1;
    #1;
    check("b0_ready", 32'(key_ready_b), 32'd1);
    @(posedge clk);
    @(negedge clk);
    key_valid_b = 1'b0;
    for (int i = 0; i < 36; i++) begin
      col_b = ($urandom_range(0, 1) == 0) ? 4'b1101 : 4'b1110;
      #1;
      check("b0_contact", 32'(contact_b), 32'(i < 20));
      check("b0_row", 32'(row_b), 32'(model_row(4'h9, col_b, i < 20)));
      check("b0_done_low", 32'(key_done_b), 32'd0);
      @(negedge clk);
    end
    #1;
    check("b0_done", 32'({key_done_b, key_ready_b, busy_b}), 32'b110);
    @(negedge clk);
    check("b0_done_end", 32'(key_done_b), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
